serial_arith_sequencer: RTL and testbench
=========================================

// Module: serial_arith_sequencer
// PURPOSE
//   Bit-serial front end for the 1-bit arithmetic slice (arithmetic_circuit). Accepts WIDTH-bit
//   operands and a 3-bit op over valid/ready, feeds the slice one bit per cycle LSB-first,
//   registers the carry between bits and assembles the WIDTH-bit result plus carry-out.
//   Sits directly upstream of the slice; the slice's combinational d/cout return in the same cycle.
// PARAMETERS
//   WIDTH   8   operand/result width in bits, >= 2
// PORTS
//   clk_i         in   1      clock, all state updates on rising edge
//   rst_i         in   1      synchronous, active-high reset
//   in_valid_i    in   1      operand/op request valid
//   in_ready_o    out  1      sequencer can accept a request (IDLE only)
//   op_i          in   3      {sel[1:0], cin}: slice B-select and initial carry
//   a_i, b_i      in   WIDTH  operands
//   slice_a_o     out  1      current A bit to slice
//   slice_b_o     out  1      current B bit to slice
//   slice_cin_o   out  1      current carry to slice
//   slice_sel_o   out  2      B-mux select to slice (held for whole operation)
//   slice_d_i     in   1      slice sum bit
//   slice_cout_i  in   1      slice carry-out
//   out_valid_o   out  1      result valid
//   out_ready_i   in   1      consumer accepts result
//   result_o      out  WIDTH  assembled result
//   cout_o        out  1      final carry-out (from MSB)
//   busy_o        out  1      high in RUN
// BEHAVIOUR
//   - States: IDLE -> RUN -> DONE -> IDLE. Reset: state=IDLE, in_ready_o=1, out_valid_o=0,
//     busy_o=0, result_o=0, cout_o=0, all slice_* outputs 0, bit counter 0.
//   - IDLE: in_ready_o=1. On in_valid_i&in_ready_o: latch a_i, b_i, op_i into shift regs;
//     carry_q<=op_i[0]; cnt<=0; go RUN. in_ready_o is 0 in RUN and DONE (no overlap).
//   - RUN: slice_a_o=a_q[0], slice_b_o=b_q[0], slice_cin_o=carry_q, slice_sel_o=op_q[2:1].
//     Each cycle: res_q<={slice_d_i, res_q[WIDTH-1:1]}; a_q,b_q shift right; carry_q<=slice_cout_i;
//     cnt++. When cnt==WIDTH-1 that cycle: go DONE. Exactly WIDTH RUN cycles.
//   - DONE: out_valid_o=1; result_o=res_q, cout_o=carry_q held stable until out_valid&out_ready,
//     then IDLE. Slice outputs forced 0 outside RUN.
//   - Latency: accept edge at cycle 0 -> out_valid_o high from cycle WIDTH+1 (WIDTH RUN cycles).
//     Back-to-back throughput: one op per WIDTH+2 cycles with out_ready_i tied high.
//   - Op semantics (via slice): 000 A+B, 001 A+B+1, 010 A+~B, 011 A-B, 100 A, 101 A+1,
//     110 A-1, 111 A. Result is modulo 2^WIDTH; carry from MSB on cout_o.
//   - Boundaries: in_valid_i ignored outside IDLE; out_ready_i ignored outside DONE;
//     rst_i in any state aborts operation, discards partial result, returns to reset values next edge;
//     operand inputs may change freely after acceptance.
// CONFIGURATION
//   SERIAL_SEQ_FLAGS_EN defined: adds outputs zero_o (result_o==0) and ovf_o (signed overflow =
//     carry into MSB XOR carry out of MSB; carry into MSB = carry_q during last RUN cycle, registered).
//     Both reset 0, valid with out_valid_o, held in DONE.
//   Not defined: ports zero_o/ovf_o absent, no flag logic.
// STRUCTURE
//   Shared package alu_pkg: op encodings (OP_ADD..OP_TFR_B1 localparams), SEL_B/SEL_NOT_B/
//     SEL_ZERO/SEL_ONE constants, state enum {ST_IDLE, ST_RUN, ST_DONE}.
//   No sub-modules: single FSM + shift registers + $clog2(WIDTH) counter; slice instantiated by parent.
// TESTING  (WIDTH=8, bench models slice behaviourally or instantiates arithmetic_circuit)
//   op=000 A=8'h3C B=8'h0F -> result 8'h4B, cout 0, out_valid at cycle 9 after accept.
//   op=011 A=8'h05 B=8'h07 -> result 8'hFE, cout 0; op=011 A=B=8'h55 -> 8'h00, cout 1 (zero_o=1 if EN).
//   op=001 A=8'h7F B=8'h00 -> 8'h80, cout 0, ovf_o=1 with SERIAL_SEQ_FLAGS_EN; op=110 A=0 -> 8'hFF, cout 0.
//   out_ready_i low 5 cycles in DONE -> result/cout stable, in_ready_o=0, new in_valid_i ignored.
//   rst_i asserted at RUN cycle 4 -> next cycle IDLE, in_ready_o=1, out_valid_o=0, result_o=0;
//     following op completes correctly.
//   Random ops/operands, out_ready_i randomly throttled, 1000 txns vs reference model; slice_* all 0 outside RUN.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial arithmetic front end: op codes, slice B-select
// codes and the sequencer state type.
package alu_pkg;

  localparam logic [2:0] OP_ADD     = 3'b000;  // A + B
  localparam logic [2:0] OP_ADD_C1  = 3'b001;  // A + B + 1
  localparam logic [2:0] OP_ADD_NB  = 3'b010;  // A + ~B
  localparam logic [2:0] OP_SUB     = 3'b011;  // A - B
  localparam logic [2:0] OP_TFR_A   = 3'b100;  // A
  localparam logic [2:0] OP_INC_A   = 3'b101;  // A + 1
  localparam logic [2:0] OP_DEC_A   = 3'b110;  // A - 1
  localparam logic [2:0] OP_TFR_B1  = 3'b111;  // A + all-ones + 1 == A, carry set

  localparam logic [1:0] SEL_B      = 2'b00;
  localparam logic [1:0] SEL_NOT_B  = 2'b01;
  localparam logic [1:0] SEL_ZERO   = 2'b10;
  localparam logic [1:0] SEL_ONE    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic [1:0] op_sel(input logic [2:0] op);
    return op[2:1];
  endfunction

  function automatic logic op_cin(input logic [2:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/serial_arith_sequencer.sv
// Bit-serial sequencer feeding an external 1-bit arithmetic slice LSB-first.
// Optional zero/overflow flags are built when SERIAL_SEQ_FLAGS_EN is defined.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready for a request, slice inputs parked at 0
// ST_RUN  | one operand bit per cycle through the slice, WIDTH cycles
// ST_DONE | result and carry-out held until the consumer takes them
module serial_arith_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             slice_a_o,
  output logic             slice_b_o,
  output logic             slice_cin_o,
  output logic [1:0]       slice_sel_o,
  input  logic             slice_d_i,
  input  logic             slice_cout_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             busy_o
`ifdef SERIAL_SEQ_FLAGS_EN
  ,
  output logic             zero_o,
  output logic             ovf_o
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [1:0]       r_sel;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic [WIDTH-1:0] w_res_shift;

  assign w_accept    = (r_state == ST_IDLE) && in_valid_i;
  assign w_run       = (r_state == ST_RUN);
  assign w_last      = w_run && (r_cnt == LAST_BIT);
  assign w_res_shift = {slice_d_i, r_res[WIDTH-1:1]};

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    slice_a_o   = 1'b0;
    slice_b_o   = 1'b0;
    slice_cin_o = 1'b0;
    slice_sel_o = 2'b00;
    case (r_state)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy_o      = 1'b1;
        slice_a_o   = r_a[0];
        slice_b_o   = r_b[0];
        slice_cin_o = r_carry;
        slice_sel_o = r_sel;
        if (r_cnt == LAST_BIT) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operands shift out LSB-first while sum bits enter the result from the top.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sel   <= 2'b00;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= a_i;
      r_b     <= b_i;
      r_sel   <= op_sel(op_i);
      r_carry <= op_cin(op_i);
      r_cnt   <= '0;
    end else if (w_run) begin
      r_res   <= w_res_shift;
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= slice_cout_i;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign result_o = r_res;
  assign cout_o   = r_carry;

`ifdef SERIAL_SEQ_FLAGS_EN
  logic r_zero;
  logic r_ovf;

  // Overflow: carry into the MSB (r_carry on the last bit) differs from carry out of it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_last) begin
      r_zero <= (w_res_shift == '0);
      r_ovf  <= r_carry ^ slice_cout_i;
    end
  end

  assign zero_o = r_zero;
  assign ovf_o  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_arith_sequencer.sv
// Self-checking bench for serial_arith_sequencer (WIDTH=8) with a behavioural slice model.
// Flag checks are compiled in when SERIAL_SEQ_FLAGS_EN is defined.
module tb_serial_arith_sequencer;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [2:0]   op_i;
  logic [W-1:0] a_i, b_i;
  logic         slice_a_o, slice_b_o, slice_cin_o;
  logic [1:0]   slice_sel_o;
  logic         slice_d_i, slice_cout_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] result_o;
  logic         cout_o;
  logic         busy_o;
`ifdef SERIAL_SEQ_FLAGS_EN
  logic         zero_o, ovf_o;
`endif

  int checks   = 0;
  int failures = 0;

  serial_arith_sequencer #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .slice_a_o(slice_a_o), .slice_b_o(slice_b_o), .slice_cin_o(slice_cin_o),
    .slice_sel_o(slice_sel_o), .slice_d_i(slice_d_i), .slice_cout_i(slice_cout_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .cout_o(cout_o), .busy_o(busy_o)
`ifdef SERIAL_SEQ_FLAGS_EN
    , .zero_o(zero_o), .ovf_o(ovf_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Behavioural 1-bit slice: full adder with B-mux.
  logic w_bm;
  assign w_bm = (slice_sel_o == SEL_B)     ? slice_b_o :
                (slice_sel_o == SEL_NOT_B) ? ~slice_b_o :
                (slice_sel_o == SEL_ZERO)  ? 1'b0 : 1'b1;
  assign slice_d_i    = slice_a_o ^ w_bm ^ slice_cin_o;
  assign slice_cout_i = (slice_a_o & w_bm) | (slice_cin_o & (slice_a_o ^ w_bm));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: whole-word arithmetic on the selected B operand.
  function automatic logic [W:0] ref_sum(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] bs;
    case (op[2:1])
      2'd0:    bs = b;
      2'd1:    bs = ~b;
      2'd2:    bs = '0;
      default: bs = '1;
    endcase
    return {1'b0, a} + {1'b0, bs} + (W+1)'(op[0]);
  endfunction

  function automatic logic ref_ovf(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] bs;
    logic [W:0]   s;
    case (op[2:1])
      2'd0:    bs = b;
      2'd1:    bs = ~b;
      2'd2:    bs = '0;
      default: bs = '1;
    endcase
    s = ref_sum(op, a, b);
    return (a[W-1] == bs[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // Slice inputs must be parked whenever the sequencer is not running.
  always @(negedge clk_i) begin
    if (!busy_o && !rst_i)
      chk("slice_idle", {27'd0, slice_sel_o, slice_a_o, slice_b_o, slice_cin_o}, 32'd0);
  end

  // One transaction; lat counts cycles with the handshake cycle as cycle 0.
  task automatic run_txn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int stall, output logic [W-1:0] res, output logic co,
                         output logic zf, output logic of, output int lat);
    int guard;
    in_valid_i = 1'b1; op_i = op; a_i = a; b_i = b; out_ready_i = 1'b0;
    guard = 0;
    while (!in_ready_o && guard < 100) begin step(); guard++; end
    chk("accept_wait", in_ready_o, 1);
    step();
    in_valid_i = 1'b0;
    a_i = W'($urandom); b_i = W'($urandom); op_i = 3'($urandom);
    chk("busy_in_run", busy_o, 1);
    chk("ready_in_run", in_ready_o, 0);
    lat = 1;
    while (!out_valid_o && lat < 60) begin step(); lat++; end
    chk("valid_wait", out_valid_o, 1);
    res = result_o; co = cout_o;
`ifdef SERIAL_SEQ_FLAGS_EN
    zf = zero_o; of = ovf_o;
`else
    zf = 1'b0; of = 1'b0;
`endif
    for (int i = 0; i < stall; i++) begin
      in_valid_i = 1'b1;
      step();
      chk("stall_valid", out_valid_o, 1);
      chk("stall_in_ready", in_ready_o, 0);
      chk("stall_result", result_o, res);
      chk("stall_cout", cout_o, co);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    chk("release_valid", out_valid_o, 0);
    chk("release_idle", {in_ready_o, busy_o}, 2'b10);
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         co;
    logic         zf;
    logic         of;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [W-1:0] res;
    logic         co, zf, of;
    int           lat, guard, nacc;
    int           acc_t[3];
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    logic [W:0]   exp_s;

    vecs[0]  = '{OP_ADD,    8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{OP_SUB,    8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{OP_SUB,    8'h55, 8'h55, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{OP_ADD_C1, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{OP_DEC_A,  8'h00, 8'hA5, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{OP_ADD,    8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{OP_ADD_NB, 8'h0F, 8'hF0, 8'h1E, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{OP_TFR_A,  8'h80, 8'h33, 8'h80, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{OP_INC_A,  8'hFF, 8'h12, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{OP_TFR_B1, 8'h80, 8'h00, 8'h80, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{OP_SUB,    8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{OP_DEC_A,  8'h80, 8'h5A, 8'h7F, 1'b1, 1'b0, 1'b1};

    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    op_i = '0; a_i = '0; b_i = '0;
    step(); step(); step();
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_cout", cout_o, 0);
`ifdef SERIAL_SEQ_FLAGS_EN
    chk("rst_flags", {zero_o, ovf_o}, 0);
`endif
    rst_i = 1'b0;
    step();

    foreach (vecs[i]) begin
      run_txn(vecs[i].op, vecs[i].a, vecs[i].b, i % 3, res, co, zf, of, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].res);
      chk($sformatf("vec%0d_cout", i), co, vecs[i].co);
      chk($sformatf("vec%0d_latency", i), lat, W + 1);
`ifdef SERIAL_SEQ_FLAGS_EN
      chk($sformatf("vec%0d_zero", i), zf, vecs[i].zf);
      chk($sformatf("vec%0d_ovf", i), of, vecs[i].of);
`endif
    end

    // Long back-pressure in DONE with competing requests on the input.
    run_txn(OP_ADD, 8'h3C, 8'h0F, 5, res, co, zf, of, lat);
    chk("stall5_result", res, 8'h4B);
    chk("stall5_cout", co, 0);
    step();
    chk("stall5_no_accept", busy_o, 0);

    // Reset in the middle of RUN discards the partial result.
    in_valid_i = 1'b1; op_i = OP_SUB; a_i = 8'h55; b_i = 8'h55;
    step();
    in_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("pre_abort_busy", busy_o, 1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("abort_in_ready", in_ready_o, 1);
    chk("abort_out_valid", out_valid_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_result", result_o, 0);
    chk("abort_cout", cout_o, 0);
    run_txn(OP_ADD, 8'h3C, 8'h0F, 0, res, co, zf, of, lat);
    chk("post_abort_result", res, 8'h4B);
    chk("post_abort_cout", co, 0);

    // Back-to-back throughput with both handshakes held high.
    in_valid_i = 1'b1; out_ready_i = 1'b1; op_i = OP_ADD; a_i = 8'h01; b_i = 8'h02;
    nacc = 0; guard = 0;
    while (nacc < 3 && guard < 100) begin
      if (in_ready_o) begin acc_t[nacc] = guard; nacc++; end
      step(); guard++;
    end
    in_valid_i = 1'b0;
    chk("b2b_accepts", nacc, 3);
    chk("b2b_period0", acc_t[1] - acc_t[0], W + 2);
    chk("b2b_period1", acc_t[2] - acc_t[1], W + 2);
    guard = 0;
    while (!in_ready_o && guard < 50) begin step(); guard++; end
    out_ready_i = 1'b0;
    chk("b2b_drain", in_ready_o, 1);

    for (int t = 0; t < 1000; t++) begin
      rop = 3'($urandom); ra = W'($urandom); rb = W'($urandom);
      run_txn(rop, ra, rb, $urandom_range(0, 3), res, co, zf, of, lat);
      exp_s = ref_sum(rop, ra, rb);
      chk("rand_result", res, exp_s[W-1:0]);
      chk("rand_cout", co, exp_s[W]);
`ifdef SERIAL_SEQ_FLAGS_EN
      chk("rand_zero", zf, exp_s[W-1:0] == '0);
      chk("rand_ovf", of, ref_ovf(rop, ra, rb));
`endif
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
